// File: rtl/luka_fetch_pkg.sv
// Shared types and default geometry for the Luka instruction-fetch stage.
package luka_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

    localparam int DEF_INSTR_W      = 19;
    localparam int DEF_INSTR_ADDR_W = 10;
    localparam int DEF_NUM_INSTRS   = 1024;

endpackage

// File: rtl/stg_1_pc_gen.sv
// Combinational next-PC logic for the fetch stage: sequential increment with
// end-of-program wrap, and range-checked redirect.
module stg_1_pc_gen
    import luka_fetch_pkg::*;
#(
    parameter int INSTR_ADDR_W = DEF_INSTR_ADDR_W,
    parameter int NUM_INSTRS   = DEF_NUM_INSTRS
) (
    input  logic [INSTR_ADDR_W-1:0] pc,
    input  fetch_state_t            state,
    input  logic                    stall,
    input  logic                    redir_valid,
    input  logic [INSTR_ADDR_W-1:0] redir_addr,
    output logic [INSTR_ADDR_W-1:0] next_pc,
    output logic                    wrap,
    output logic                    redir_oor,
    output logic                    redirect,
    output logic                    issue
);

    // One extra bit so NUM_INSTRS == 2**INSTR_ADDR_W is still representable.
    localparam logic [INSTR_ADDR_W:0] LIMIT = (INSTR_ADDR_W+1)'(NUM_INSTRS);

    logic [INSTR_ADDR_W:0] pc_inc;

    always_comb begin
        pc_inc    = {1'b0, pc} + {{INSTR_ADDR_W{1'b0}}, 1'b1};
        wrap      = (pc_inc == LIMIT);
        redir_oor = ({1'b0, redir_addr} >= LIMIT);
        redirect  = redir_valid && (state != IDLE);
        issue     = (state == RUN) && !stall && !redir_valid;

        next_pc = pc;
        if (redirect) begin
            next_pc = redir_oor ? '0 : redir_addr;
        end else if (issue) begin
            next_pc = wrap ? '0 : pc_inc[INSTR_ADDR_W-1:0];
        end
    end

endmodule

// File: rtl/stg_1_fetch.sv
// Luka pipeline stage 1: PC register, async imem read, IF/ID pipeline register,
// start/halt FSM, redirect squash and retired-fetch counter.
module stg_1_fetch
    import luka_fetch_pkg::*;
#(
    parameter int INSTR_W      = DEF_INSTR_W,
    parameter int INSTR_ADDR_W = DEF_INSTR_ADDR_W,
    parameter int NUM_INSTRS   = DEF_NUM_INSTRS,
    parameter int RESET_PC     = 0,
    parameter int WRAP_EN      = 1,
    parameter int CNT_W        = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stall,
    input  logic                    redir_valid,
    input  logic [INSTR_ADDR_W-1:0] redir_addr,
    output logic [INSTR_ADDR_W-1:0] imem_addr,
    input  logic [INSTR_W-1:0]      imem_rdata,
    output logic [INSTR_ADDR_W-1:0] r_if_pc,
    output logic [INSTR_W-1:0]      r_id_instr,
    output logic [INSTR_ADDR_W-1:0] r_id_pc,
    output logic                    r_id_valid,
    output logic [CNT_W-1:0]        r_fetch_cnt,
    output logic                    halted,
    output logic                    redir_err,
    output logic [9:0]              LEDR
);

    fetch_state_t            state, state_nxt;
    logic [INSTR_ADDR_W-1:0] pc_nxt;
    logic                    wrap, redir_oor, redirect, issue;

    stg_1_pc_gen #(
        .INSTR_ADDR_W (INSTR_ADDR_W),
        .NUM_INSTRS   (NUM_INSTRS)
    ) u_pc_gen (
        .pc          (r_if_pc),
        .state       (state),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_addr  (redir_addr),
        .next_pc     (pc_nxt),
        .wrap        (wrap),
        .redir_oor   (redir_oor),
        .redirect    (redirect),
        .issue       (issue)
    );

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (redirect)                             state_nxt = RUN;
                else if (issue && wrap && (WRAP_EN == 0)) state_nxt = HALT;
            end
            HALT: if (start || redir_valid) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_if_pc     <= INSTR_ADDR_W'(RESET_PC);
            r_id_instr  <= '0;
            r_id_pc     <= '0;
            r_id_valid  <= 1'b0;
            r_fetch_cnt <= '0;
            redir_err   <= 1'b0;
        end else begin
            r_if_pc <= pc_nxt;
            if (redirect) begin
                r_id_valid <= 1'b0;
                r_id_instr <= '0;
                if (redir_oor) redir_err <= 1'b1;
            end else if (issue) begin
                r_id_instr  <= imem_rdata;
                r_id_pc     <= r_if_pc;
                r_id_valid  <= 1'b1;
                r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
            end else if (state != RUN) begin
                // Outside RUN a bubble drains every cycle; a stalled RUN holds.
                r_id_valid <= 1'b0;
                r_id_instr <= '0;
            end
        end
    end

    assign imem_addr = r_if_pc;
    assign halted    = (state == HALT);
    assign LEDR      = 10'(r_if_pc);

endmodule

// File: doc/stg_1_fetch.md
# stg_1_fetch

Parametrised instruction-fetch stage for the Luka pipeline: holds the program counter, reads the instruction memory (asynchronous read port), and registers the fetched instruction, its PC and a valid bit into the IF/ID pipeline register. It adds the following:
- start/halt control
- stall hold
- branch/jump redirect with wrong-path squash
- selectable wrap-or-halt at end of program
- a retired-fetch counter

It feeds stage 2 (decode) directly.

## Interface
Parameters:
- INSTR_W, 19, instruction width in bits
- INSTR_ADDR_W, 10, PC / instruction-address width
- NUM_INSTRS, 1024, program length; valid PCs are 0..NUM_INSTRS-1
- RESET_PC, 0, PC loaded on reset
- WRAP_EN, 1, 1: PC wraps to 0 after NUM_INSTRS-1; 0: block halts
- CNT_W, 16, width of the fetch counter

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-low reset
- start  in  1  leave IDLE/HALT and begin fetching at the current PC
- stall  in  1  decode back-pressure; hold PC and IF/ID register
- redir_valid  in  1  redirect request from a later stage
- redir_addr  in  INSTR_ADDR_W  redirect target
- imem_addr  out  INSTR_ADDR_W  instruction-memory read address; always equals r_if_pc
- imem_rdata  in  INSTR_W  instruction-memory read data, same cycle as imem_addr
- r_if_pc  out  INSTR_ADDR_W  current fetch PC
- r_id_instr  out  INSTR_W  registered instruction to decode
- r_id_pc  out  INSTR_ADDR_W  PC of r_id_instr
- r_id_valid  out  1  r_id_instr is a real instruction
- r_fetch_cnt  out  CNT_W  number of instructions issued to ID since reset
- halted  out  1  FSM in HALT
- redir_err  out  1  sticky; set when redir_addr >= NUM_INSTRS
- LEDR  out  10  r_if_pc zero-extended or truncated to 10 bits

## Operation
The FSM has three states: IDLE, RUN and HALT.

State transitions:
- Reset goes to IDLE.
- IDLE goes to RUN when start=1.
- RUN goes to HALT when WRAP_EN=0 and an instruction at PC NUM_INSTRS-1 is issued.
- HALT goes to RUN when start=1 or redir_valid=1.

Issue condition: in RUN with stall=0 and redir_valid=0, the instruction issues. On issue:
- r_id_instr ← imem_rdata
- r_id_pc ← r_if_pc
- r_id_valid ← 1
- r_fetch_cnt += 1; it wraps modulo 2^CNT_W.

Next PC on issue:
- r_if_pc+1, compared at INSTR_ADDR_W+1 bits.
- If r_if_pc+1 == NUM_INSTRS, the next PC is 0, in both WRAP_EN modes.

Redirect (any state except IDLE; takes priority over stall and halt):
- r_if_pc ← redir_addr, or 0 with redir_err set if out of range.
- r_id_valid ← 0 and r_id_instr ← 0 (squash).
- The counter is not incremented.
- The FSM goes to RUN.

Stall in RUN without redirect: r_if_pc, r_id_* and the counter all hold.

In IDLE and HALT with no redirect:
- PC holds.
- r_id_valid ← 0 and r_id_instr ← 0 each cycle, so a bubble drains.

In IDLE, redir_valid is ignored.

## Timing
Reset values (the cycle after reset=0 is sampled):
- r_if_pc=RESET_PC
- r_id_instr=0, r_id_pc=0, r_id_valid=0
- r_fetch_cnt=0
- halted=0, redir_err=0
- state IDLE

Reset wins over every other input, including a mid-redirect or a stall.

Latency:
- start sampled at edge N; the first issue is at edge N+1; r_id_valid=1 after edge N+1.
- One instruction per cycle while unstalled. Fetch-to-ID latency is 1 cycle.

Redirect:
- redir_valid at edge N: r_if_pc=redir_addr after N.
- Target instruction is in ID after N+1. Redirect penalty: 1 bubble.

The imem read is combinational from r_if_pc, so no extra fetch latency.

halted asserts the cycle after the last issue (WRAP_EN=0). r_id_valid for that last instruction is 1 in the same cycle.

## Structure
- Shared package luka_fetch_pkg: fetch_state_t enum {IDLE, RUN, HALT} and default INSTR_W / INSTR_ADDR_W / NUM_INSTRS localparams, sourced from the existing specs header values.
- One natural sub-module, stg_1_pc_gen. It is purely combinational and produces the next PC, the wrap flag and the redirect-range error from r_if_pc, redirect inputs, stall and state. The FSM, IF/ID register and counter remain in stg_1_fetch.

## Test plan
- Reset then start with NUM_INSTRS=4, WRAP_EN=1, memory {A,B,C,D}:
  - r_id_instr sequence is A,B,C,D,A with r_id_pc 0,1,2,3,0.
  - r_fetch_cnt=5 after 5 issues.
- WRAP_EN=0, NUM_INSTRS=4:
  - after D issues, halted=1 and r_id_valid drops to 0 next cycle.
  - a start pulse resumes at PC 0.
- Stall high 3 cycles with B in ID:
  - r_id_instr=B, r_if_pc=2 and r_fetch_cnt hold.
  - C appears one cycle after stall drops.
- redir_valid=1, redir_addr=1 while stall=1 and PC=3: next cycle r_if_pc=1 and r_id_valid=0; B is in ID the following cycle.
- redir_addr=7 with NUM_INSTRS=4: r_if_pc=0 and redir_err=1, which stays set until reset.
- reset=0 asserted for 1 cycle mid-RUN with stall=1: all outputs return to reset values and the state is IDLE; fetch does not resume without start.
